// File: rtl/spi_reg_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_reg_master
// Purpose  : Mode-0 SPI initiator issuing two-byte {cmd, data} register
//            transactions and returning the byte captured during byte 2.
// Revision : 1.0 - initial release
// ============================================================================
module spi_reg_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_read,
    input  logic [2:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       sclk,
    output logic       cs_n,
    output logic       mosi,
    input  logic       miso
);

    localparam int            CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_HOLD  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t        state_q;
    logic [CW-1:0] div_cnt_q;
    logic [3:0]    bit_cnt_q;
    // Bits still to be sent; the bit currently on mosi is already out of here.
    logic [14:0]   shift_q;
    // Only the last eight MISO samples (byte 2) are ever reported.
    logic [7:0]    cap_q;
    logic          ready_q;
    logic          busy_q;
    logic          rsp_valid_q;
    logic [7:0]    rsp_rdata_q;
    logic          sclk_q;
    logic          cs_n_q;
    logic          mosi_q;

    logic          w_div_wrap;
    assign w_div_wrap = (div_cnt_q == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            div_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            cap_q       <= '0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            sclk_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid && ready_q) begin
                        shift_q   <= {4'b0000, req_addr, (req_read ? 8'h00 : req_wdata)};
                        mosi_q    <= req_read;
                        cs_n_q    <= 1'b0;
                        ready_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        div_cnt_q <= '0;
                        bit_cnt_q <= '0;
                        state_q   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (!w_div_wrap) begin
                        div_cnt_q <= div_cnt_q + CW'(1);
                    end else begin
                        div_cnt_q <= '0;
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                            cap_q  <= {cap_q[6:0], miso};
                        end else begin
                            sclk_q <= 1'b0;
                            if (bit_cnt_q == 4'd15) begin
                                state_q <= S_HOLD;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                                mosi_q    <= shift_q[14];
                                shift_q   <= {shift_q[13:0], 1'b0};
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (!w_div_wrap) begin
                        div_cnt_q <= div_cnt_q + CW'(1);
                    end else begin
                        div_cnt_q   <= '0;
                        cs_n_q      <= 1'b1;
                        mosi_q      <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= cap_q;
                        state_q     <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (!w_div_wrap) begin
                        div_cnt_q <= div_cnt_q + CW'(1);
                    end else begin
                        div_cnt_q <= '0;
                        ready_q   <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready = ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign sclk      = sclk_q;
    assign cs_n      = cs_n_q;
    assign mosi      = mosi_q;

endmodule
`default_nettype wire
